// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format types and the representability check used by the
// encoder datapath and by anything that needs to predict its error flag.
package imm_types;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ERR_CNT_W     = 16;
  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

  // True when v[31:lo] is a pure sign extension (all zeros or all ones).
  function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lo);
    logic [31:0] shifted;
    shifted = 32'($signed(v) >>> lo);
    return (shifted == '0) || (shifted == '1);
  endfunction

  function automatic logic imm_fits(input imm_sel_e sel, input logic [31:0] imm);
    logic fits;
    case (sel)
      IMM_I, IMM_S: fits = upper_uniform(imm, 11);
      IMM_B:        fits = upper_uniform(imm, 12) && !imm[0];
      IMM_U:        fits = (imm[11:0] == 12'h000);
      IMM_J:        fits = upper_uniform(imm, 20) && !imm[0];
      default:      fits = 1'b0;
    endcase
    return fits;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Scatters an immediate into the bit positions of the selected instruction
// format; every bit outside that field is taken from the base instruction.
module imm_field_pack
  import imm_types::*;
(
  input  imm_sel_e    sel,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] instr
);

  // Out-of-range immediates are still packed from their truncated low bits.
  always_comb begin
    instr = base;
    case (sel)
      IMM_I: begin
        instr[31:20] = imm[11:0];
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
      end
      IMM_U: begin
        instr[31:12] = imm[31:12];
      end
      IMM_J: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
      end
      default: begin
        instr = base;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 captures the request and its range check,
// S2 holds the merged instruction until the consumer takes it.
module imm_encoder
  import imm_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  imm_sel_e    in_sel,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);

  logic        s1_valid_q, s1_valid_d;
  imm_sel_e    s1_sel_q,   s1_sel_d;
  logic [31:0] s1_imm_q,   s1_imm_d;
  logic [31:0] s1_base_q,  s1_base_d;
  logic        s1_err_q,   s1_err_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q,   s2_err_d;

  logic [15:0] err_count_q, err_count_d;

  logic        s1_advance;
  logic        s1_load;
  logic        out_fire;
  logic [31:0] packed_instr;

  assign s1_advance = !s2_valid_q || out_ready;
  assign s1_load    = !s1_valid_q || s1_advance;
  assign out_fire   = s2_valid_q && out_ready;

  imm_field_pack u_pack (
    .sel   (s1_sel_q),
    .imm   (s1_imm_q),
    .base  (s1_base_q),
    .instr (packed_instr)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sel_d   = s1_sel_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s1_err_d   = s1_err_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sel_d  = in_sel;
        s1_imm_d  = in_imm;
        s1_base_d = in_base;
        s1_err_d  = !imm_fits(in_sel, in_imm);
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = packed_instr;
        s2_err_d   = s1_err_q;
      end
    end
  end

  // Only delivered errors are counted; a stalled error result counts once.
  always_comb begin
    err_count_d = err_count_q;
    if (out_fire && s2_err_q && (err_count_q != ERR_COUNT_MAX)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sel_q    <= IMM_I;
      s1_imm_q    <= '0;
      s1_base_q   <= '0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= '0;
      s2_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sel_q    <= s1_sel_d;
      s1_imm_q    <= s1_imm_d;
      s1_base_q   <= s1_base_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not just after it.
  assign in_ready  = !rst && s1_load;
  assign out_valid = !rst && s2_valid_q;
  assign out_instr = rst ? '0 : s2_instr_q;
  assign out_err   = !rst && s2_err_q;
  assign err_count = rst ? '0 : err_count_q;

endmodule
